// File: rtl/tx_serial_param_pkg.sv
// Shared definitions for the parameterised serial transmitter: FSM state codes
// and parity mode constants.
package tx_serial_param_pkg;

  typedef enum logic [2:0] {
    REPOUSO  = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4,
    FINAL    = 3'd5
  } estado_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter used as the baud tick generator; fim is high on the wrap cycle.
module contador_m #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int N = (M > 1) ? $clog2(M) : 1;
  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  logic [N-1:0] q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == ULTIMO) ? '0 : q + N'(1);
    end
  end

  assign fim = (q == ULTIMO);

endmodule

// File: rtl/tx_serial_param.sv
// Parameterised asynchronous serial transmitter: start bit, LSB-first data,
// optional parity, one or two stop bits, then a one-cycle completion pulse.
module tx_serial_param
  import tx_serial_param_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 partida,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [2:0]           db_estado
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_err_data_bits
    $fatal(1, "tx_serial_param: DATA_BITS must be 5..8");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_err_parity
    $fatal(1, "tx_serial_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop_bits
    $fatal(1, "tx_serial_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_err_clks
    $fatal(1, "tx_serial_param: CLKS_PER_BIT must be at least 2");
  end

  localparam logic [2:0] ULTIMO_BIT    = 3'(DATA_BITS - 1);
  localparam logic [2:0] ULTIMA_PARADA = 3'(STOP_BITS - 1);

  function automatic logic paridade(input logic [DATA_BITS-1:0] w);
    return (^w) ^ (PARITY == PAR_ODD);
  endfunction

  estado_t              estado_q, estado_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [2:0]           bit_q, bit_d;
  logic                 linha_d, ocupado_d, pronto_d;
  logic                 em_quadro, tick;

  assign em_quadro = (estado_q == INICIO) || (estado_q == DADOS) ||
                     (estado_q == PARIDADE) || (estado_q == PARADA);

  // Baud counter restarts on every state change so each bit is a full period.
  contador_m #(
    .M(CLKS_PER_BIT)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .zera  (estado_d != estado_q),
    .conta (em_quadro),
    .fim   (tick)
  );

  always_comb begin
    estado_d = estado_q;
    shift_d  = shift_q;
    par_d    = par_q;
    bit_d    = bit_q;
    unique case (estado_q)
      REPOUSO: begin
        if (partida) begin
          estado_d = INICIO;
          shift_d  = dados;
          par_d    = paridade(dados);
          bit_d    = '0;
        end
      end
      INICIO: begin
        if (tick) estado_d = DADOS;
      end
      DADOS: begin
        if (tick) begin
          if (bit_q == ULTIMO_BIT) begin
            estado_d = (PARITY != PAR_NONE) ? PARIDADE : PARADA;
            bit_d    = '0;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      PARIDADE: begin
        if (tick) estado_d = PARADA;
      end
      PARADA: begin
        // bit_q doubles as the stop-bit counter; the baud counter wraps between stop bits
        if (tick) begin
          if (bit_q == ULTIMA_PARADA) begin
            estado_d = FINAL;
            bit_d    = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      FINAL: begin
        estado_d = REPOUSO;
      end
      default: begin
        estado_d = REPOUSO;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the line tracks the state without glitches.
  always_comb begin
    linha_d   = 1'b1;
    ocupado_d = 1'b0;
    pronto_d  = 1'b0;
    unique case (estado_d)
      INICIO: begin
        linha_d   = 1'b0;
        ocupado_d = 1'b1;
      end
      DADOS: begin
        linha_d   = shift_d[0];
        ocupado_d = 1'b1;
      end
      PARIDADE: begin
        linha_d   = par_d;
        ocupado_d = 1'b1;
      end
      PARADA: begin
        ocupado_d = 1'b1;
      end
      FINAL: begin
        pronto_d = 1'b1;
      end
      default: begin
        linha_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= REPOUSO;
      shift_q      <= '0;
      par_q        <= 1'b0;
      bit_q        <= '0;
      saida_serial <= 1'b1;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      bit_q        <= bit_d;
      saida_serial <= linha_d;
      ocupado      <= ocupado_d;
      pronto       <= pronto_d;
    end
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_tx_serial_param.sv
// Bench for tx_serial_param: three configurations (7E1, 7O1, 8N2) at 4 clocks/bit,
// each frame checked cycle by cycle against a frame model built from bit positions.
module tb_tx_serial_param;

  localparam int C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       partida_a, partida_b, partida_c;
  logic [6:0] dados_a, dados_b;
  logic [7:0] dados_c;
  logic       line_a, line_b, line_c;
  logic       ocup_a, ocup_b, ocup_c;
  logic       pronto_a, pronto_b, pronto_c;
  logic [2:0] est_a, est_b, est_c;

  int         sel;
  logic       line_m, ocup_m, pronto_m;
  logic [2:0] est_m;

  int checks   = 0;
  int failures = 0;

  tx_serial_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(C)) u_a (
    .clock(clk), .reset(rst_n), .partida(partida_a), .dados(dados_a),
    .saida_serial(line_a), .ocupado(ocup_a), .pronto(pronto_a), .db_estado(est_a));

  tx_serial_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(C)) u_b (
    .clock(clk), .reset(rst_n), .partida(partida_b), .dados(dados_b),
    .saida_serial(line_b), .ocupado(ocup_b), .pronto(pronto_b), .db_estado(est_b));

  tx_serial_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(C)) u_c (
    .clock(clk), .reset(rst_n), .partida(partida_c), .dados(dados_c),
    .saida_serial(line_c), .ocupado(ocup_c), .pronto(pronto_c), .db_estado(est_c));

  always_comb begin
    line_m = line_c; ocup_m = ocup_c; pronto_m = pronto_c; est_m = est_c;
    case (sel)
      0: begin line_m = line_a; ocup_m = ocup_a; pronto_m = pronto_a; est_m = est_a; end
      1: begin line_m = line_b; ocup_m = ocup_b; pronto_m = pronto_b; est_m = est_b; end
      default: ;
    endcase
  end

  function automatic int cfg_db(input int s);
    return (s == 2) ? 8 : 7;
  endfunction
  function automatic int cfg_par(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 0);
  endfunction
  function automatic int cfg_sb(input int s);
    return (s == 2) ? 2 : 1;
  endfunction
  function automatic int frame_bits(input int s);
    return 1 + cfg_db(s) + ((cfg_par(s) != 0) ? 1 : 0) + cfg_sb(s);
  endfunction

  // Line level for bit slot b of a frame carrying word w.
  function automatic int exp_line(input int s, input logic [7:0] w, input int b);
    int db;
    int p;
    db = cfg_db(s);
    if (b == 0) return 0;
    if (b <= db) return int'(w[b-1]);
    if (cfg_par(s) != 0 && b == db + 1) begin
      p = 0;
      for (int k = 0; k < db; k++) p = p ^ int'(w[k]);
      return (cfg_par(s) == 2) ? (p ^ 1) : p;
    end
    return 1;
  endfunction

  function automatic int exp_state(input int s, input int b);
    if (b == 0) return 1;
    if (b <= cfg_db(s)) return 2;
    if (cfg_par(s) != 0 && b == cfg_db(s) + 1) return 3;
    return 4;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s sel=%0d observed=%0h expected=%0h t=%0t", tag, sel, obs, exp, $time);
    end
  endtask

  task automatic set_in(input int s, input logic p, input logic [7:0] w);
    case (s)
      0: begin partida_a = p; dados_a = w[6:0]; end
      1: begin partida_b = p; dados_b = w[6:0]; end
      default: begin partida_c = p; dados_c = w; end
    endcase
  endtask

  task automatic accept(input int s, input logic [7:0] w);
    sel = s;
    set_in(s, 1'b1, w);
    @(posedge clk);
  endtask

  task automatic check_frame(input int s, input logic [7:0] w, input bit release_p, input bit mid);
    int nb;
    int b;
    nb = frame_bits(s);
    for (int i = 0; i <= nb * C; i++) begin
      @(negedge clk);
      if (i == 0 && release_p) set_in(s, 1'b0, w);
      if (i < nb * C) begin
        b = i / C;
        chk("line", int'(line_m), exp_line(s, w, b));
        chk("ocupado", int'(ocup_m), 1);
        chk("pronto", int'(pronto_m), 0);
        chk("estado", int'(est_m), exp_state(s, b));
      end else begin
        chk("final_line", int'(line_m), 1);
        chk("final_ocupado", int'(ocup_m), 0);
        chk("final_pronto", int'(pronto_m), 1);
        chk("final_estado", int'(est_m), 5);
      end
      if (mid && i == 3 * C + 1) set_in(s, 1'b1, ~w);
      if (mid && i == 3 * C + 2) set_in(s, 1'b0, ~w);
    end
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk("idle_line", int'(line_m), 1);
    chk("idle_ocupado", int'(ocup_m), 0);
    chk("idle_pronto", int'(pronto_m), 0);
    chk("idle_estado", int'(est_m), 0);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    int s;

    rst_n = 1'b0;
    sel = 0;
    partida_a = 1'b0; partida_b = 1'b0; partida_c = 1'b0;
    dados_a = '0; dados_b = '0; dados_c = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("rst_line", int'(line_m), 1);
      chk("rst_ocupado", int'(ocup_m), 0);
      chk("rst_pronto", int'(pronto_m), 0);
      chk("rst_estado", int'(est_m), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames: 7E1 and 7O1 with 0x41, 8N2 with 0xFF
    accept(0, 8'h41); check_frame(0, 8'h41, 1'b1, 1'b0); check_idle();
    accept(1, 8'h41); check_frame(1, 8'h41, 1'b1, 1'b0); check_idle();
    accept(2, 8'hFF); check_frame(2, 8'hFF, 1'b1, 1'b0); check_idle();

    for (int k = 0; k < 6; k++) begin
      s = $urandom_range(2);
      w = 8'($urandom);
      accept(s, w); check_frame(s, w, 1'b1, 1'b0); check_idle();
    end

    // Second request with a different word arrives mid-frame
    w = 8'($urandom);
    accept(0, w); check_frame(0, w, 1'b1, 1'b1); check_idle();

    // Request held high: a new frame follows the FINAL and one idle cycle
    w  = 8'($urandom);
    w2 = ~w;
    accept(0, w);
    #1 set_in(0, 1'b1, w2);
    check_frame(0, w, 1'b0, 1'b0);
    check_idle();
    check_frame(0, w2, 1'b1, 1'b0);
    check_idle();

    // Reset during data bit 3, then a fresh frame right after release
    w = 8'($urandom);
    accept(2, w);
    #1 set_in(2, 1'b0, w);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_line", int'(line_m), 1);
    chk("abort_ocupado", int'(ocup_m), 0);
    chk("abort_pronto", int'(pronto_m), 0);
    chk("abort_estado", int'(est_m), 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_line", int'(line_m), 1);
      chk("abort_hold_pronto", int'(pronto_m), 0);
    end
    rst_n = 1'b1;
    w2 = 8'($urandom);
    accept(2, w2); check_frame(2, w2, 1'b1, 1'b0); check_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
